// File: rtl/uart_rx_frame.sv
// UART receive deserializer: 16x oversampling with midpoint sampling of
// start/d0..d7/even-parity/stop frames, one completion pulse per frame.
module uart_rx_frame #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] Rx_BAUD_SELECT,
    output logic [7:0] Data,
    output logic       Rx_FERROR,
    output logic       Rx_PERROR,
    output logic       Rx_DONE
);

    localparam int unsigned   TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_next;

    logic          rx_meta, rxs, rxs_prev;
    logic [13:0]   baud_n, div_n, div_cnt;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          par_bit;
    logic          tick, bit_tick;
    logic          start_det, mid_ok, data_smp, par_smp, commit;

    // Clocks per oversample tick at 50 MHz.
    always_comb begin
        case (Rx_BAUD_SELECT)
            3'd0:    baud_n = 14'd10417;
            3'd1:    baud_n = 14'd2604;
            3'd2:    baud_n = 14'd651;
            3'd3:    baud_n = 14'd326;
            3'd4:    baud_n = 14'd163;
            3'd5:    baud_n = 14'd81;
            3'd6:    baud_n = 14'd54;
            default: baud_n = 14'd27;
        endcase
    end

    assign tick     = (div_cnt == div_n - 14'd1);
    assign bit_tick = tick && (tick_cnt == TICK_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_det  = 1'b0;
        mid_ok     = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        commit     = 1'b0;
        if (!Rx_EN) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rxs_prev && !rxs) begin
                        start_det  = 1'b1;
                        state_next = START;
                    end
                end
                START: begin
                    if (tick && (tick_cnt == TICK_MID)) begin
                        if (rxs) begin
                            state_next = IDLE;
                        end else begin
                            mid_ok     = 1'b1;
                            state_next = DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        data_smp = 1'b1;
                        if (bit_idx == 3'd7) state_next = PARITY;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        par_smp    = 1'b1;
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Synchronizer resets to the idle line level so release cannot fake a start edge.
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            rxs_prev  <= 1'b1;
            div_n     <= 14'd27;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            Data      <= '0;
            Rx_FERROR <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_DONE   <= 1'b0;
        end else begin
            rx_meta  <= RxD;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            Rx_DONE  <= 1'b0;
            if (!Rx_EN || state == IDLE) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_idx  <= '0;
                if (start_det) div_n <= baud_n;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 14'd1;
                if (tick) tick_cnt <= (tick_cnt == TICK_END) ? '0 : tick_cnt + 1'b1;
                if (mid_ok) begin
                    tick_cnt <= '0;
                    bit_idx  <= '0;
                end
                if (data_smp) begin
                    shift[bit_idx] <= rxs;
                    bit_idx        <= bit_idx + 3'd1;
                end
                if (par_smp) par_bit <= rxs;
                if (commit) begin
                    Data      <= shift;
                    Rx_FERROR <= ~rxs;
                    Rx_PERROR <= (^shift) ^ par_bit;
                    Rx_DONE   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and random frames against a frame-level
// model of the expected byte/flags sequence and completion timing.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       reset;
    logic       Rx_EN;
    logic       RxD;
    logic [2:0] Rx_BAUD_SELECT;
    logic [7:0] Data;
    logic       Rx_FERROR;
    logic       Rx_PERROR;
    logic       Rx_DONE;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned t_start = 0;

    logic [7:0]  mdl_data = 8'h00;
    logic        mdl_fe = 1'b0;
    logic        mdl_pe = 1'b0;

    logic [7:0]  q_data[$];
    logic        q_fe[$];
    logic        q_pe[$];
    int unsigned q_cyc[$];
    logic [7:0]  e_data[$];
    logic        e_fe[$];
    logic        e_pe[$];

    uart_rx_frame #(.OVERSAMPLE(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .Rx_EN          (Rx_EN),
        .RxD            (RxD),
        .Rx_BAUD_SELECT (Rx_BAUD_SELECT),
        .Data           (Data),
        .Rx_FERROR      (Rx_FERROR),
        .Rx_PERROR      (Rx_PERROR),
        .Rx_DONE        (Rx_DONE)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every clock with Rx_DONE high is one recorded completion.
    always @(negedge clk) begin
        if (Rx_DONE === 1'b1) begin
            q_data.push_back(Data);
            q_fe.push_back(Rx_FERROR);
            q_pe.push_back(Rx_PERROR);
            q_cyc.push_back(cyc);
        end
    end

    // Clocks per oversample tick: 50 MHz / (16 * baud), rounded to nearest.
    function automatic int unsigned div_for(input int unsigned code);
        int unsigned baud;
        case (code)
            0:       baud = 300;
            1:       baud = 1200;
            2:       baud = 4800;
            3:       baud = 9600;
            4:       baud = 19200;
            5:       baud = 38400;
            6:       baud = 57600;
            default: baud = 115200;
        endcase
        return (50_000_000 + 8 * baud) / (16 * baud);
    endfunction

    task automatic wait_cyc(input int unsigned k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int unsigned obs,
                               input int unsigned lo, input int unsigned hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        e_data.push_back(b);
        e_fe.push_back(~stop);
        e_pe.push_back(par_flip);
        mdl_data = b;
        mdl_fe   = ~stop;
        mdl_pe   = par_flip;
    endtask

    // Drives the first nbits of a frame; parity bit is the even parity of b, optionally inverted.
    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop,
                             input int unsigned n, input int unsigned nbits, input logic scramble);
        logic [10:0] f;
        f = {stop, (^b) ^ par_flip, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            RxD = f[i];
            if (i == 0) t_start = cyc;
            wait_cyc(16 * n);
            if (i == 0 && scramble) Rx_BAUD_SELECT = 3'($urandom_range(0, 6));
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, q_data.size(), e_data.size());
        for (int i = 0; i < e_data.size() && i < q_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), q_data[i], e_data[i]);
            check($sformatf("%s_ferr%0d", tag, i), q_fe[i], e_fe[i]);
            check($sformatf("%s_perr%0d", tag, i), q_pe[i], e_pe[i]);
        end
        q_data.delete();
        q_fe.delete();
        q_pe.delete();
        q_cyc.delete();
        e_data.delete();
        e_fe.delete();
        e_pe.delete();
    endtask

    task automatic check_held(input string tag);
        check({tag, "_data"}, Data, mdl_data);
        check({tag, "_ferr"}, Rx_FERROR, mdl_fe);
        check({tag, "_perr"}, Rx_PERROR, mdl_pe);
        check({tag, "_done"}, Rx_DONE, 1'b0);
    endtask

    initial begin
        int unsigned n;
        int unsigned lat;
        logic [7:0]  rb;
        logic        rpf, rst;

        reset          = 1'b1;
        Rx_EN          = 1'b1;
        RxD            = 1'b1;
        Rx_BAUD_SELECT = 3'd7;
        #2 reset = 1'b0;
        wait_cyc(4);
        check_held("reset");
        reset = 1'b1;
        wait_cyc(4);

        // 0xA5 at 115200, completion latency from start edge
        Rx_BAUD_SELECT = 3'd7;
        n = div_for(7);
        expect_frame(8'hA5, 1'b0, 1'b1);
        send_bits(8'hA5, 1'b0, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        lat = (q_cyc.size() > 0) ? q_cyc[0] - t_start : 0;
        check_range("a5_latency", lat, 168 * n + 2, 168 * n + 4);
        drain("a5");

        // wrong parity bit
        Rx_BAUD_SELECT = 3'd6;
        n = div_for(6);
        expect_frame(8'h3C, 1'b1, 1'b1);
        send_bits(8'h3C, 1'b1, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        drain("perr");

        // stop bit low, line held low two more bits, then a valid frame
        Rx_BAUD_SELECT = 3'd7;
        n = div_for(7);
        expect_frame(8'h81, 1'b0, 1'b0);
        send_bits(8'h81, 1'b0, 1'b0, n, 11, 1'b0);
        wait_cyc(32 * n);
        RxD = 1'b1;
        wait_cyc(16 * n);
        drain("break");
        expect_frame(8'h55, 1'b0, 1'b1);
        send_bits(8'h55, 1'b0, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        drain("after_break");
        check("ferr_cleared", Rx_FERROR, 1'b0);

        // quarter-bit glitch on idle line at 4800
        Rx_BAUD_SELECT = 3'd2;
        n = div_for(2);
        RxD = 1'b0;
        wait_cyc(4 * n);
        RxD = 1'b1;
        wait_cyc(10 * n);
        drain("glitch");
        check_held("glitch_hold");

        // Rx_EN dropped mid-DATA
        Rx_BAUD_SELECT = 3'd7;
        n = div_for(7);
        send_bits(8'h6B, 1'b0, 1'b1, n, 5, 1'b0);
        Rx_EN = 1'b0;
        wait_cyc(2);
        RxD = 1'b1;
        wait_cyc(16 * 7 * n);
        drain("en_abort");
        check_held("en_hold");
        Rx_EN = 1'b1;
        wait_cyc(16 * n);
        expect_frame(8'h7E, 1'b0, 1'b1);
        send_bits(8'h7E, 1'b0, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        drain("en_next");

        // reset pulsed mid-DATA
        send_bits(8'h93, 1'b0, 1'b1, n, 5, 1'b0);
        reset    = 1'b0;
        RxD      = 1'b1;
        mdl_data = 8'h00;
        mdl_fe   = 1'b0;
        mdl_pe   = 1'b0;
        wait_cyc(3);
        check_held("rst_abort");
        reset = 1'b1;
        wait_cyc(16 * 7 * n);
        drain("rst_quiet");
        expect_frame(8'h7E, 1'b0, 1'b1);
        send_bits(8'h7E, 1'b0, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        drain("rst_next");

        // back-to-back frames with no idle gap
        expect_frame(8'h01, 1'b0, 1'b1);
        expect_frame(8'hFE, 1'b0, 1'b1);
        send_bits(8'h01, 1'b0, 1'b1, n, 11, 1'b0);
        send_bits(8'hFE, 1'b0, 1'b1, n, 11, 1'b0);
        wait_cyc(20);
        drain("b2b");

        // random frames with random error injection; baud select scrambled mid-frame
        for (int k = 0; k < 3; k++) begin
            rb  = 8'($urandom);
            rpf = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 3) != 0);
            Rx_BAUD_SELECT = 3'd7;
            expect_frame(rb, rpf, rst);
            send_bits(rb, rpf, rst, n, 11, 1'b1);
            Rx_BAUD_SELECT = 3'd7;
            RxD = 1'b1;
            wait_cyc(16 * n);
        end
        drain("rand");
        check_held("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
